mac_acc: RTL
============

// Module: mac_acc
// PURPOSE
//  Pipelined multi-channel MAC with temporal accumulation. Each d_en beat
//  multiplies INPUT_NUM data/weight pairs and reduces them through a
//  registered adder tree. ACC_LEN consecutive beats are accumulated into one
//  convolution output, then bias is added, the result is requantised
//  (round + arithmetic shift), ReLU is applied if enabled, and the value is
//  saturated. It sits between the line-buffer window feed and the output
//  plane writer, and accepts one beat per cycle.
// PARAMETERS
//  INPUT_NUM   4   channel pairs per beat (>=1); adder tree padded to PAD=2**$clog2(INPUT_NUM)
//  WDP         9   signed data width
//  WDP_WEIGHT  9   signed weight width
//  WDP_BIAS    13  signed bias width
//  WDP_ACC     24  accumulator / tree width (>= WDP+WDP_WEIGHT+$clog2(PAD*ACC_LEN))
//  WDP_OUT     9   signed output width
//  ACC_LEN     9   beats per output (>=1)
//  SHIFT       6   requantise right shift (0 = no shift, no rounding)
//  RELU_EN     1   1: negative results clamp to 0
// PORTS
//  clk     in   1                    clock, rising edge
//  rstn    in   1                    asynchronous reset, active low
//  clr     in   1                    sync flush: abort current group
//  d_en    in   1                    beat valid
//  d       in   WDP*INPUT_NUM        packed data, channel 0 in MSBs
//  w       in   WDP_WEIGHT*INPUT_NUM packed weights, same order
//  bias    in   WDP_BIAS             bias, sampled on the last beat of a group
//  q_en_b1 out  1                    asserted one cycle before q_en
//  q_en    out  1                    output valid, 1-cycle pulse per group
//  q       out  WDP_OUT              result
// BEHAVIOUR
//  - Reset: all pipeline registers, the beat counter, acc, q, q_en and q_en_b1 are 0.
//  - The input beat counter cnt (0..ACC_LEN-1) advances only on d_en. first = (cnt==0),
//    last = (cnt==ACC_LEN-1). cnt wraps to 0 after last. ACC_LEN=1 means every beat is first and last.
//  - first/last/valid flags and the sampled bias travel down the pipeline with each beat.
//    Idle cycles (d_en=0) between beats are allowed and do not change the result.
//  - Stage 1: mul[i] = signed(d[i])*signed(w[i]), sign-extended to WDP_ACC.
//    Padded lanes are 0.
//  - Tree: $clog2(PAD) registered pairwise add stages in WDP_ACC, with modulo wrap.
//  - Acc stage: if the beat is first, acc <= sum; otherwise acc <= acc + sum (wraps).
//    A beat that is both first and last takes the first rule.
//  - Post stage, on a last beat: t = acc + sext(bias);
//    r = SHIFT ? (t + 2**(SHIFT-1)) >>> SHIFT : t; r = (RELU_EN && r<0) ? 0 : r;
//    q = saturate r to [-2**(WDP_OUT-1), 2**(WDP_OUT-1)-1].
//  - Latency LAT = $clog2(PAD)+3 cycles from the last beat's d_en edge to q_en.
//    q_en_b1 is high at LAT-1. q holds its value until the next q_en.
//  - Throughput: back-to-back groups with no bubble. q_en pulses every ACC_LEN beats.
//  - clr: cnt <= 0, every in-flight valid flag is killed, and acc <= 0.
//    No q_en is produced for the aborted group. A d_en in the same cycle as clr
//    is discarded. The next beat after clr is first.
//  - rstn asserted mid-group: everything returns to reset state immediately.
//    The partial group is lost.
// TESTING (INPUT_NUM=4, ACC_LEN=3, SHIFT=2, WDP_OUT=9 unless noted)
//  1 All d=1, w=1, bias=0, 3 consecutive beats -> single q_en at LAT=5 after
//    beat 3, q=(12+2)>>>2=3, q_en_b1 one cycle earlier.
//  2 d=-1, w=1, bias=0: RELU_EN=1 -> q=0; RELU_EN=0 -> q=(-12+2)>>>2=-3.
//    Also bias=5 with d=w=1 -> q=(17+2)>>>2=4.
//  3 d=255, w=255 on all lanes -> q saturates to 255.
//    d=-256, w=255, RELU_EN=0 -> q=-256.
//  4 Same stimulus as test 1 with 2 idle cycles between beats, then 2 groups
//    back-to-back -> q=3 each time, q_en pulses 3 cycles apart.
//  5 clr after beat 2, then 3 fresh beats d=w=1 -> exactly one q_en, q=3.
//    Repeat with clr and d_en in the same cycle -> that beat is ignored.
//  6 rstn low for 1 cycle mid-group -> q, q_en and q_en_b1 are 0 at once.
//    A following full group -> q=3, with no spurious q_en.

Source files
------------

// File: rtl/mac_acc_if.sv
// Beat-in / result-out bundle for the pipelined MAC accumulator.
// The producer (window feed) drives the beat side through the master modport.
// The MAC drives the result side through the slave modport.
interface mac_acc_if #(
  parameter int INPUT_NUM  = 4,
  parameter int WDP        = 9,
  parameter int WDP_WEIGHT = 9,
  parameter int WDP_BIAS   = 13,
  parameter int WDP_OUT    = 9
);
  logic                            clr;
  logic                            d_en;
  logic [WDP*INPUT_NUM-1:0]        d;
  logic [WDP_WEIGHT*INPUT_NUM-1:0] w;
  logic signed [WDP_BIAS-1:0]      bias;
  logic                            q_en_b1;
  logic                            q_en;
  logic signed [WDP_OUT-1:0]       q;

  modport master (
    output clr, d_en, d, w, bias,
    input  q_en_b1, q_en, q
  );

  modport slave (
    input  clr, d_en, d, w, bias,
    output q_en_b1, q_en, q
  );
endinterface

// File: rtl/mac_acc.sv
// Pipelined multi-channel MAC with temporal accumulation.
// Pipeline: input register -> multiply -> registered adder tree -> accumulator
// -> bias / requantise / ReLU / saturate. Each beat carries its own valid,
// first/last and bias tags down the pipe, so idle cycles between beats are harmless.
module mac_acc #(
  parameter int INPUT_NUM  = 4,
  parameter int WDP        = 9,
  parameter int WDP_WEIGHT = 9,
  parameter int WDP_BIAS   = 13,
  parameter int WDP_ACC    = 24,
  parameter int WDP_OUT    = 9,
  parameter int ACC_LEN    = 9,
  parameter int SHIFT      = 6,
  parameter int RELU_EN    = 1
) (
  input logic      clk,
  input logic      rstn,
  mac_acc_if.slave bus
);

  localparam int LEVELS = $clog2(INPUT_NUM);
  localparam int PAD    = 1 << LEVELS;
  localparam int CW     = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  // Two guard bits so bias addition and rounding never wrap before saturation.
  localparam int W      = WDP_ACC + 2;
  localparam int SH1    = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [W-1:0] RND   = (SHIFT > 0) ? (W'(1) << SH1) : W'(0);
  localparam logic signed [W-1:0] R_MAX = W'((1 << (WDP_OUT - 1)) - 1);
  localparam logic signed [W-1:0] R_MIN = ~R_MAX;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LEN - 1);

  logic [CW-1:0]              cnt;
  logic                       beat_first;
  logic                       beat_last;

  logic signed [WDP-1:0]        lane_d [PAD];
  logic signed [WDP_WEIGHT-1:0] lane_w [PAD];

  logic                         in_vld;
  logic                         in_first;
  logic                         in_last;
  logic signed [WDP_BIAS-1:0]   in_bias;
  logic signed [WDP-1:0]        in_d [PAD];
  logic signed [WDP_WEIGHT-1:0] in_w [PAD];

  logic signed [WDP_ACC-1:0]  node [LEVELS+1][PAD];
  logic [LEVELS:0]            p_vld;
  logic [LEVELS:0]            p_first;
  logic [LEVELS:0]            p_last;
  logic signed [WDP_BIAS-1:0] p_bias [LEVELS+1];

  logic signed [WDP_ACC-1:0]  acc;
  logic                       acc_vld;
  logic                       acc_last;
  logic signed [WDP_BIAS-1:0] acc_bias;

  logic signed [W-1:0]        t;
  logic signed [W-1:0]        r;
  logic signed [WDP_OUT-1:0]  q_next;
  logic signed [WDP_OUT-1:0]  q_reg;
  logic                       q_en_reg;

  function automatic logic signed [WDP_ACC-1:0] mul_ext(
    input logic signed [WDP-1:0]        a,
    input logic signed [WDP_WEIGHT-1:0] b
  );
    logic signed [WDP+WDP_WEIGHT-1:0] p;
    p = a * b;
    return WDP_ACC'(p);
  endfunction

  assign beat_first = (cnt == '0);
  assign beat_last  = (cnt == CNT_LAST);

  // Unpack the channel lanes (channel 0 sits in the MSBs); padded lanes are zero.
  for (genvar gi = 0; gi < PAD; gi++) begin : g_lane
    if (gi < INPUT_NUM) begin : g_real
      assign lane_d[gi] = bus.d[WDP*(INPUT_NUM-gi)-1 -: WDP];
      assign lane_w[gi] = bus.w[WDP_WEIGHT*(INPUT_NUM-gi)-1 -: WDP_WEIGHT];
    end else begin : g_pad
      assign lane_d[gi] = '0;
      assign lane_w[gi] = '0;
    end
  end

  // Beat position within the group; a flush restarts the group.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (bus.clr) begin
      cnt <= '0;
    end else if (bus.d_en) begin
      cnt <= beat_last ? '0 : cnt + CW'(1);
    end
  end

  // Input register: capture the beat with its tags; a beat coinciding with a flush is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_vld   <= 1'b0;
      in_first <= 1'b0;
      in_last  <= 1'b0;
      in_bias  <= '0;
      for (int i = 0; i < PAD; i++) begin
        in_d[i] <= '0;
        in_w[i] <= '0;
      end
    end else begin
      in_vld   <= bus.d_en & ~bus.clr;
      in_first <= beat_first;
      in_last  <= beat_last;
      in_bias  <= bus.bias;
      for (int i = 0; i < PAD; i++) begin
        in_d[i] <= lane_d[i];
        in_w[i] <= lane_w[i];
      end
    end
  end

  // Multiply stage (level 0) followed by the pairwise reduction levels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_vld   <= '0;
      p_first <= '0;
      p_last  <= '0;
      for (int l = 0; l <= LEVELS; l++) begin
        p_bias[l] <= '0;
        for (int i = 0; i < PAD; i++) begin
          node[l][i] <= '0;
        end
      end
    end else begin
      p_vld[0]   <= in_vld & ~bus.clr;
      p_first[0] <= in_first;
      p_last[0]  <= in_last;
      p_bias[0]  <= in_bias;
      for (int i = 0; i < PAD; i++) begin
        node[0][i] <= mul_ext(in_d[i], in_w[i]);
      end
      for (int l = 1; l <= LEVELS; l++) begin
        p_vld[l]   <= p_vld[l-1] & ~bus.clr;
        p_first[l] <= p_first[l-1];
        p_last[l]  <= p_last[l-1];
        p_bias[l]  <= p_bias[l-1];
        for (int i = 0; i < (PAD >> l); i++) begin
          node[l][i] <= node[l-1][2*i] + node[l-1][2*i+1];
        end
      end
    end
  end

  // Temporal accumulator: a first beat restarts the sum, later beats add on (wrapping).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc      <= '0;
      acc_vld  <= 1'b0;
      acc_last <= 1'b0;
      acc_bias <= '0;
    end else if (bus.clr) begin
      acc      <= '0;
      acc_vld  <= 1'b0;
      acc_last <= 1'b0;
    end else begin
      acc_vld  <= p_vld[LEVELS];
      acc_last <= p_last[LEVELS];
      if (p_vld[LEVELS]) begin
        acc      <= p_first[LEVELS] ? node[LEVELS][0] : acc + node[LEVELS][0];
        acc_bias <= p_bias[LEVELS];
      end
    end
  end

  // Bias, round-half-up shift, optional ReLU, then clamp to the output range.
  always_comb begin
    t      = W'(acc) + W'(acc_bias);
    r      = (t + RND) >>> SHIFT;
    q_next = r[WDP_OUT-1:0];
    if ((RELU_EN != 0) && (r < 0)) begin
      r = '0;
    end
    if (r > R_MAX) begin
      q_next = R_MAX[WDP_OUT-1:0];
    end else if (r < R_MIN) begin
      q_next = R_MIN[WDP_OUT-1:0];
    end else begin
      q_next = r[WDP_OUT-1:0];
    end
  end

  // Result register: q updates only when a completed group leaves the accumulator.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_reg    <= '0;
      q_en_reg <= 1'b0;
    end else if (bus.clr) begin
      q_en_reg <= 1'b0;
    end else begin
      q_en_reg <= acc_vld & acc_last;
      if (acc_vld && acc_last) begin
        q_reg <= q_next;
      end
    end
  end

  assign bus.q_en_b1 = acc_vld & acc_last;
  assign bus.q_en    = q_en_reg;
  assign bus.q       = q_reg;

endmodule
